// File: rtl/mem_pkg.sv
// Shared constants and encodings for the memory second-port arbiter.
package mem_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int LINE_BITS   = 64;
    localparam int MEM_LATENCY = 7;

    // A one-cycle latency would give $clog2 a zero-width counter, so keep at least one bit.
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        GAP
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: the port that was not granted last wins a tie.
module rr_arb2
    import mem_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   take,
    output logic   grant_valid,
    output owner_t grant_owner
);

    logic prio_d;

    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_I;
        if (d_req && (!i_req || prio_d))
            grant_owner = OWN_D;
    end

    // Priority moves to the other port whenever a grant is actually taken.
    always_ff @(posedge clk) begin
        if (!reset_n)
            prio_d <= 1'b0;
        else if (take && grant_valid)
            prio_d <= (grant_owner == OWN_I);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory's second port between I-cache fills and D-cache accesses,
// one fixed-latency access at a time with a forced strobe-low gap afterwards.
module mem_port_arbiter
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [LINE_BITS-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata
);

    arb_state_t       state;
    owner_t           owner;
    logic [CNT_W-1:0] cnt;
    logic             grant_valid;
    owner_t           grant_owner;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req       (i_req),
        .d_req       (d_req),
        .take        (state == IDLE),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // The strobe/address registers double as the latched request, so they stay
    // stable for the whole access no matter what the requester does meanwhile.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= OWN_I;
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner <= grant_owner;
                        cnt   <= CNT_W'(MEM_LATENCY - 1);
                        state <= ACCESS;
                        if (grant_owner == OWN_D) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_we ? d_wdata : '0;
                            mem_read  <= !d_we;
                            mem_write <= d_we;
                        end else begin
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= DONE;
                        if (owner == OWN_I) begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            if (!mem_write)
                                d_rdata <= mem_rdata;
                            d_ack <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= GAP;
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the shared memory's second access port (fixed-latency, 64-bit line read / 16-bit word write) between the instruction-cache fill path and the data-cache read/write path. It holds one request at a time, drives a single-level read or write strobe for exactly the memory latency, captures the returned line, and acknowledges the owner. It then forces a strobe-low gap so the memory sees a fresh rising edge for every access. Sits between the I/D cache controllers and the memory model at the top level.

## Interface
- WORD_SIZE, 16, address and write-data width
- LINE_BITS, 64, read-line width (4 words)
- MEM_LATENCY, 7, cycles the strobe must be held before the memory's read data is valid
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- i_req  in  1  instruction fill request; held until i_ack
- i_addr  in  WORD_SIZE  instruction line address (low 2 bits ignored by memory)
- i_ack  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  LINE_BITS  returned instruction line
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = word write, 0 = line read
- d_addr  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  write word
- d_ack  out  1  one-cycle pulse: access complete, d_rdata valid for reads
- d_rdata  out  LINE_BITS  returned data line
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  WORD_SIZE  memory address
- mem_wdata  out  WORD_SIZE  memory write data (top level gates it onto the tri-state bus when mem_write=1)
- mem_rdata  in  LINE_BITS  memory read data

## Operation
- FSM states: IDLE, ACCESS, DONE, GAP.
- IDLE: if any req high, grant one and latch owner, addr, we, wdata; go ACCESS, load cnt = MEM_LATENCY-1. No req: stay.
- Arbitration: round-robin on simultaneous requests; the port not granted last wins. After reset I has priority. A lone request always wins.
- ACCESS: mem_read = !we, mem_write = we, mem_addr/mem_wdata from latched values, all held stable. cnt decrements each cycle; when cnt==0, capture mem_rdata into owner's rdata register (reads only) and go DONE.
- DONE: strobes low; owner's ack = 1 for this cycle only; go GAP.
- GAP: strobes low; requests ignored (requester drops req the cycle after ack); go IDLE.
- i_rdata/d_rdata hold their last captured value until the next capture for that port; writes do not alter d_rdata.
- Writes on I port do not exist; d_we is sampled only at grant.
- Request dropped before ack: illegal; the arbiter completes the latched access regardless and still pulses ack.
- Reset (any state, including mid-ACCESS): state IDLE, cnt 0, mem_read/mem_write/i_ack/d_ack 0, mem_addr/mem_wdata 0, i_rdata/d_rdata 0, round-robin pointer to I. The aborted access is not acknowledged.

## Timing
- Cycle 0: req sampled high in IDLE. Cycles 1..MEM_LATENCY: strobe high (7 cycles default). Capture at the edge ending cycle MEM_LATENCY. Cycle MEM_LATENCY+1: ack high, strobe low. Cycle MEM_LATENCY+2: GAP. Cycle MEM_LATENCY+3: IDLE, may grant.
- Request-to-ack latency MEM_LATENCY+1 cycles; back-to-back throughput one access per MEM_LATENCY+3 cycles; strobe low ≥ 3 cycles between accesses (guaranteed rising edge).
- cnt width $clog2(MEM_LATENCY); MEM_LATENCY ≥ 1.
- All outputs registered; no combinational path from req to strobes or ack.

## Structure
- Shared package mem_pkg: WORD_SIZE, LINE_BITS, MEM_LATENCY constants; state enum {IDLE, ACCESS, DONE, GAP}; owner encoding (OWN_I=0, OWN_D=1).
- Optional sub-module rr_arb2 (two-requester round-robin grant with last-owner pointer); everything else flat.

## Test plan
- Single I read, i_addr=0x0024 -> mem_read high cycles 1..7, mem_addr=0x0024, i_ack in cycle 8, i_rdata = line at 0x0024..0x0027 (0xf41c_6100_f01c_6000).
- D write d_addr=0x00c7, d_wdata=0xbeef then D read 0x00c4 -> mem_write 7 cycles with mem_wdata=0xbeef, d_ack; ≥3 low cycles; read returns upper word 0xbeef.
- i_req and d_req rise same cycle after reset -> I granted first, D strobe starts exactly 10 cycles after I strobe starts; next simultaneous pair grants D first.
- Continuous D requests with I pending -> grants alternate I/D; neither starves; each ack exactly one cycle wide.
- reset_n low during cycle 4 of ACCESS -> next cycle all strobes/acks 0, no ack issued; request after reset completes normally with full 7-cycle strobe.
- No requests for 50 cycles -> mem_read=mem_write=0, acks 0, rdata registers unchanged.
